imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter RST_HOLD, default 4, SHALL set the number of cycles core_rst stays high after loading completes.
REQ-003 clk  input  1  single system clock; all logic SHALL be rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high at a rising edge.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  instruction word.
REQ-012 core_rst  output  1  reset to the single-cycle core, active-high.
REQ-013 busy, done, err  output  1 each  status flags.

Function
REQ-014 States SHALL be IDLE, HDR, LOAD, CHK, HOLD, DONE and ERR.
REQ-015 IDLE, DONE or ERR with start=1 SHALL go to HDR, clearing the byte counter, word address, length and checksum; start in any other state SHALL be ignored.
REQ-016 in_ready SHALL be 1 only in HDR, LOAD and CHK.
REQ-017 HDR SHALL accept 2 bytes, little-endian, forming a 16-bit word count N.
REQ-018 N=0 SHALL go to CHK (macro on) or HOLD (macro off); N>2^ADDR_W SHALL go to ERR; otherwise HDR SHALL go to LOAD.
REQ-019 LOAD SHALL assemble 4 bytes little-endian (first byte = bits 7:0) into one word.
REQ-020 imem_we SHALL pulse high for exactly one cycle, the cycle after the 4th byte's handshake, with imem_addr = word index (0..N-1) and imem_wdata = assembled word.
REQ-021 After word N-1 is written, LOAD SHALL go to CHK (macro on) or HOLD (macro off).
REQ-022 in_valid low SHALL stall with no state change; no timeout SHALL exist.
REQ-023 HOLD SHALL keep core_rst high for exactly RST_HOLD cycles, then go to DONE.
REQ-024 core_rst SHALL be 0 only in DONE.
REQ-025 busy SHALL be 1 in HDR, LOAD, CHK and HOLD; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-026 ERR SHALL keep core_rst high and SHALL leave only on start or rst.
REQ-027 Address arithmetic SHALL be ADDR_W bits; N=2^ADDR_W SHALL write every address once, with no wrap write.

Reset
REQ-028 On rst=1 at a rising edge: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0.
REQ-029 rst SHALL override start and in_valid in the same cycle, and reset mid-load SHALL abandon the session with no further imem_we.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, CHK SHALL accept 1 byte; it SHALL go to HOLD if the byte equals the XOR of all header and payload bytes, otherwise to ERR.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN, the CHK state and checksum register SHALL be absent and the stream SHALL carry no checksum byte.

Structure
REQ-032 A shared package imem_loader_pkg SHALL hold the state encoding, the header length (2) and bytes per word (4).
REQ-033 One sub-module, byte_packer (4-byte shift into 32-bit word, word_ready pulse), SHALL be instantiated; all other logic SHALL stay in imem_loader.

Verification
REQ-034 Reset held 2 cycles, then released -> all outputs at reset values, core_rst=1, state IDLE.
REQ-035 start; bytes 02 00, 13 05 A0 00, 93 05 10 00, checksum (macro on) -> writes addr0=0x00A00513 and addr1=0x00100593; core_rst low exactly 4 cycles after the last byte phase; done=1.
REQ-036 Same stream with in_valid toggling every other cycle -> identical writes; imem_we never asserted while stalled.
REQ-037 Header 00 00 -> no imem_we; core_rst deasserts after HOLD; done=1.
REQ-038 Header 01 01 (N=257, ADDR_W=8) -> err=1, no imem_we, core_rst stays 1.
REQ-039 rst pulsed after 6 payload bytes, then a fresh start and valid 1-word session -> only the new word is written, at addr0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// State encoding, header length and packing width.
package imem_loader_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd3;
`endif
    localparam logic [2:0] S_HOLD = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: little-endian shift of four bytes,
// one-cycle word_ready pulse after the fourth byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_en,
    input  logic [7:0]  in_data,
    output logic        last,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt        <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (in_en) begin
                word       <= {in_data, word[31:8]};
                cnt        <= cnt + 2'd1;
                word_ready <= last;
            end
        end
    end

    assign last = (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CAP = 1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER = S_CHK;
    logic [7:0] csum;
`else
    localparam logic [2:0] S_AFTER = S_HOLD;
`endif

    logic [2:0]        state;
    logic              hcnt;
    logic [15:0]       len;
    logic [15:0]       n_hdr;
    logic [ADDR_W-1:0] widx;
    logic [15:0]       hold_cnt;
    logic              fire;
    logic              start_ok;
    logic              last_word;
    logic              pk_en;
    logic              pk_last;
    logic              pk_ready;
    logic [31:0]       pk_word;

    always_comb begin
        in_ready = (state == S_HDR) || (state == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state == S_CHK) in_ready = 1'b1;
`endif
    end

    assign fire      = in_valid && in_ready;
    assign start_ok  = start && ((state == S_IDLE) ||
                       (state == S_DONE) || (state == S_ERR));
    assign n_hdr     = {in_data, len[7:0]};
    assign pk_en     = fire && (state == S_LOAD);
    // widx still names the word being assembled when its 4th byte lands
    assign last_word = (32'(widx) == 32'(len) - 32'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .in_en      (pk_en),
        .in_data    (in_data),
        .last       (pk_last),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hcnt     <= 1'b0;
            len      <= '0;
            widx     <= '0;
            hold_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (pk_ready) widx <= widx + 1'b1;
            if (state != S_HOLD) hold_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (fire && state != S_CHK) csum <= csum ^ in_data;
`endif
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok) begin
                        state <= S_HDR;
                        hcnt  <= 1'b0;
                        len   <= '0;
                        widx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (fire) begin
                        if (hcnt != 1'(HDR_BYTES - 1)) begin
                            len[7:0] <= in_data;
                            hcnt     <= 1'b1;
                        end else begin
                            len[15:8] <= in_data;
                            if (n_hdr == 16'd0)
                                state <= S_AFTER;
                            else if (32'(n_hdr) > CAP)
                                state <= S_ERR;
                            else
                                state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pk_en && pk_last && last_word)
                        state <= S_AFTER;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (fire)
                        state <= (in_data == csum) ? S_HOLD : S_ERR;
                end
`endif
                S_HOLD: begin
                    if (hold_cnt == 16'(RST_HOLD - 1))
                        state <= S_DONE;
                    else
                        hold_cnt <= hold_cnt + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = pk_ready;
    assign imem_addr  = widx;
    assign imem_wdata = pk_word;
    assign core_rst   = (state != S_DONE);
    assign busy       = in_ready || (state == S_HOLD);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams,
// expected writes queued by stimulus, popped by a write monitor.
module tb_imem_loader;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int   checks = 0;
    int   failures = 0;
    wr_t  exp_q[$];
    wr_t  e;
    logic hs_next = 1'b0;

    imem_loader #(.ADDR_W(8), .RST_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // write monitor: every imem_we must follow a handshake and match the queue
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            chk("we_after_handshake", 32'(hs_next), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we actual addr=%h data=%h required=none",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.a));
                chk("wr_data", imem_wdata, e.d);
            end
        end
        #2;
        hs_next = in_valid && in_ready;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        int t;
        if (stall) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_cs(input logic [7:0] cs, input bit stall);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(cs, stall);
`else
        if (stall && cs == 8'hff) tick();
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic finish_session(input string tag);
        int k;
        k = 0;
        while (core_rst && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rst_hold"}, 32'(k), 32'd4);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] stream_a[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0,
                                 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_flags", {29'd0, busy, done, err}, 32'd0);

        // two-word program, no stalls
        push(8'd0, 32'h00A00513);
        push(8'd1, 32'h00100593);
        pulse_start();
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) send(stream_a[i], 1'b0);
        send_cs(8'h32, 1'b0);
        finish_session("a");

        // same program with in_valid toggling
        push(8'd0, 32'h00A00513);
        push(8'd1, 32'h00100593);
        pulse_start();
        for (int i = 0; i < 10; i++) send(stream_a[i], 1'b1);
        send_cs(8'h32, 1'b1);
        finish_session("b");

        // empty program
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send_cs(8'h00, 1'b0);
        finish_session("c");

        // oversize header: 257 words into 256-word memory
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        repeat (3) tick();
        chk("d_err", 32'(err), 32'd1);
        chk("d_core_rst", 32'(core_rst), 32'd1);
        chk("d_busy_done", {30'd0, busy, done}, 32'd0);
        chk("d_in_ready", 32'(in_ready), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h55, 1'b0);
        tick();
        chk("cs_bad_err", 32'(err), 32'd1);
`endif

        // reset mid-load abandons the session
        push(8'd0, 32'h44332211);
        pulse_start();
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_addr", 32'(imem_addr), 32'd0);
        chk("e_rst_core_rst", 32'(core_rst), 32'd1);
        chk("e_pending", 32'(exp_q.size()), 32'd0);
        push(8'd0, 32'hDEADBEEF);
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hEF, 1'b0);
        send(8'hBE, 1'b0);
        send(8'hAD, 1'b0);
        send(8'hDE, 1'b0);
        send_cs(8'h23, 1'b0);
        finish_session("e");

        // full memory: 256 words, each four copies of its index
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 256; i++) begin
            push(8'(i), 32'(i) * 32'h01010101);
            for (int j = 0; j < 4; j++) send(8'(i), 1'b0);
        end
        send_cs(8'h01, 1'b0);
        finish_session("f");

        repeat (5) tick();
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
